// File: rtl/dht_sensor_reader_if.sv
// Command-side bundle for the DHT reader: request inputs, status pulses, last good frame
// and a debug view of the FSM state.
interface dht_sensor_reader_if;
  // Handshake: start is only looked at while busy=0. Once accepted, busy stays high through
  // the read and the post-read holdoff. Exactly one of done/err pulses for one clk per
  // accepted read, unless rst aborts it. A start seen while busy=1 is dropped, not queued.
  logic        start;
  logic        mode;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  err_code;
  logic        valid;
  logic [15:0] humidity;
  logic [15:0] temperature;
  logic [7:0]  checksum;
  logic [3:0]  state_dbg;

  modport master (
    output start, mode,
    input  busy, done, err, err_code, valid, humidity, temperature, checksum, state_dbg
  );

  modport slave (
    input  start, mode,
    output busy, done, err, err_code, valid, humidity, temperature, checksum, state_dbg
  );
endinterface

// File: rtl/dht_sensor_reader.sv
// Single-wire DHT11/DHT22 reader: open-drain start pulse, response/bit decoding on a 1 us
// tick, checksum verification, per-phase timeouts and a post-read holdoff.
module dht_sensor_reader #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned DHT11_LOW_US  = 19000,
  parameter int unsigned DHT22_LOW_US  = 1100,
  parameter int unsigned RELEASE_US    = 30,
  parameter int unsigned TIMEOUT_US    = 200,
  parameter int unsigned BIT_THRESH_US = 50,
  parameter int unsigned HOLDOFF_MS    = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  inout  wire                  dat_io,
  dht_sensor_reader_if.slave   bus
);

  localparam int unsigned DIV  = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
  localparam int          DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int          MS_W  = (HOLDOFF_MS > 1) ? $clog2(HOLDOFF_MS) : 1;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_START_LOW = 4'd1;
  localparam logic [3:0] S_RELEASE   = 4'd2;
  localparam logic [3:0] S_RESP_LOW  = 4'd3;
  localparam logic [3:0] S_RESP_HIGH = 4'd4;
  localparam logic [3:0] S_RESP_END  = 4'd5;
  localparam logic [3:0] S_BIT_LOW   = 4'd6;
  localparam logic [3:0] S_BIT_HIGH  = 4'd7;
  localparam logic [3:0] S_CHECK     = 4'd8;
  localparam logic [3:0] S_FAIL      = 4'd9;
  localparam logic [3:0] S_HOLDOFF   = 4'd10;

  localparam logic [2:0] E_NO_RESP  = 3'd1;
  localparam logic [2:0] E_RESPONSE = 3'd2;
  localparam logic [2:0] E_BIT      = 3'd3;
  localparam logic [2:0] E_CHECKSUM = 3'd4;

  logic [3:0]       state;
  logic [3:0]       state_nx;
  logic [2:0]       fail_nx;
  logic [2:0]       fail_code;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [15:0]      phase_cnt;
  logic [MS_W-1:0]  ms_cnt;
  logic             ms_wrap;
  logic             timeout;
  logic [15:0]      low_target;
  logic             din_meta;
  logic             din;
  logic             drv_low;
  logic             mode_q;
  logic [39:0]      frame;
  logic [5:0]       bit_cnt;
  logic [7:0]       sum;
  logic             sum_ok;

  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [2:0]  err_code_q;
  logic        valid_q;
  logic [15:0] humidity_q;
  logic [15:0] temperature_q;
  logic [7:0]  checksum_q;

  // Open-drain: the pin is only ever pulled low or released to the external pull-up.
  assign dat_io = drv_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      din_meta <= 1'b1;
      din      <= 1'b1;
    end else begin
      din_meta <= dat_io;
      din      <= din_meta;
    end
  end

  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign low_target = mode_q ? 16'(DHT22_LOW_US) : 16'(DHT11_LOW_US);
  assign timeout    = (phase_cnt == 16'(TIMEOUT_US - 1));
  // The holdoff is counted as whole milliseconds so the phase counter stays 16 bits wide.
  assign ms_wrap    = (state == S_HOLDOFF) && (phase_cnt == 16'd999);

  assign sum    = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
  assign sum_ok = (sum == frame[7:0]);

  // Level checks only on tick cycles; the awaited level wins over a timeout on the same tick.
  always_comb begin
    state_nx = state;
    fail_nx  = 3'd0;
    case (state)
      S_IDLE: begin
        if (bus.start && !busy_q) state_nx = S_START_LOW;
      end
      S_START_LOW: begin
        if (tick && phase_cnt == low_target - 16'd1) state_nx = S_RELEASE;
      end
      S_RELEASE: begin
        if (tick && phase_cnt == 16'(RELEASE_US - 1)) state_nx = S_RESP_LOW;
      end
      S_RESP_LOW: begin
        if (tick) begin
          if (!din) begin
            state_nx = S_RESP_HIGH;
          end else if (timeout) begin
            state_nx = S_FAIL;
            fail_nx  = E_NO_RESP;
          end
        end
      end
      S_RESP_HIGH: begin
        if (tick) begin
          if (din) begin
            state_nx = S_RESP_END;
          end else if (timeout) begin
            state_nx = S_FAIL;
            fail_nx  = E_RESPONSE;
          end
        end
      end
      S_RESP_END: begin
        if (tick) begin
          if (!din) begin
            state_nx = S_BIT_LOW;
          end else if (timeout) begin
            state_nx = S_FAIL;
            fail_nx  = E_RESPONSE;
          end
        end
      end
      S_BIT_LOW: begin
        if (tick) begin
          if (din) begin
            state_nx = S_BIT_HIGH;
          end else if (timeout) begin
            state_nx = S_FAIL;
            fail_nx  = E_BIT;
          end
        end
      end
      S_BIT_HIGH: begin
        if (tick) begin
          if (!din) begin
            state_nx = (bit_cnt == 6'd39) ? S_CHECK : S_BIT_LOW;
          end else if (timeout) begin
            state_nx = S_FAIL;
            fail_nx  = E_BIT;
          end
        end
      end
      S_CHECK: begin
        if (sum_ok) begin
          state_nx = S_HOLDOFF;
        end else begin
          state_nx = S_FAIL;
          fail_nx  = E_CHECKSUM;
        end
      end
      S_FAIL: begin
        state_nx = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (tick && ms_wrap && ms_cnt == MS_W'(HOLDOFF_MS - 1)) state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      phase_cnt     <= '0;
      ms_cnt        <= '0;
      drv_low       <= 1'b0;
      mode_q        <= 1'b0;
      frame         <= '0;
      bit_cnt       <= '0;
      fail_code     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
      valid_q       <= 1'b0;
      humidity_q    <= '0;
      temperature_q <= '0;
      checksum_q    <= '0;
    end else begin
      state   <= state_nx;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      drv_low <= (state_nx == S_START_LOW);

      if (state_nx != state) begin
        phase_cnt <= '0;
        ms_cnt    <= '0;
      end else if (tick) begin
        if (ms_wrap) begin
          phase_cnt <= '0;
          ms_cnt    <= ms_cnt + MS_W'(1);
        end else begin
          phase_cnt <= phase_cnt + 16'd1;
        end
      end

      if (state == S_IDLE && state_nx == S_START_LOW) begin
        busy_q     <= 1'b1;
        mode_q     <= bus.mode;
        err_code_q <= '0;
        frame      <= '0;
        bit_cnt    <= '0;
      end

      // Bit value is the high-pulse length measured in ticks, captured on the falling edge.
      if (state == S_BIT_HIGH && tick && !din) begin
        frame   <= {frame[38:0], (phase_cnt > 16'(BIT_THRESH_US))};
        bit_cnt <= bit_cnt + 6'd1;
      end

      if (state == S_CHECK && sum_ok) begin
        humidity_q    <= frame[39:24];
        temperature_q <= frame[23:8];
        checksum_q    <= frame[7:0];
        valid_q       <= 1'b1;
        done_q        <= 1'b1;
      end

      if (state_nx == S_FAIL && state != S_FAIL) fail_code <= fail_nx;

      if (state == S_FAIL) begin
        err_q      <= 1'b1;
        err_code_q <= fail_code;
      end

      if (state == S_HOLDOFF && state_nx == S_IDLE) busy_q <= 1'b0;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;
  assign bus.valid       = valid_q;
  assign bus.humidity    = humidity_q;
  assign bus.temperature = temperature_q;
  assign bus.checksum    = checksum_q;
  assign bus.state_dbg   = state;

endmodule
